face_fetch: RTL and testbench
=============================

# face_fetch

Upstream feeder for `shader`. It walks a face list held in synchronous ROM and resolves each face's three vertex indices through a vertex ROM. For every face it presents the nine 16-bit coordinates `v1x..v3z` to `shader`, pulses `start`, and waits for `shader`'s `done` before moving to the next face. One `go` renders faces 0..`num_faces`-1 and ends with a single `all_done` pulse.

## Interface
Parameters:
- `FACE_AW`, default 10: face ROM address width.
- `VERT_AW`, default 10: vertex ROM address width.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `go`  in  1  begin traversal; sampled only in IDLE.
- `num_faces`  in  FACE_AW+1  face count; latched on an accepted `go`.
- `face_addr`  out  FACE_AW  face ROM address.
- `face_data`  in  3*VERT_AW  packed face entry {i3,i2,i1}; valid 1 cycle after its address is presented.
- `vert_addr`  out  VERT_AW  vertex ROM address.
- `vert_data`  in  48  packed vertex {z,y,x}; valid 1 cycle after its address is presented.
- `v1x,v1y,v1z,v2x,v2y,v2z,v3x,v3y,v3z`  out  16 each  coordinates of the current face, to `shader`.
- `start`  out  1  one-cycle pulse to `shader`.
- `done`  in  1  pulse from `shader` when the current face is complete.
- `busy`  out  1  traversal in progress.
- `face_idx`  out  FACE_AW  index of the current face.
- `all_done`  out  1  one-cycle pulse when traversal completes.

## Operation
- States: IDLE, FACE_REQ, FACE_LAT, V_FETCH, LAUNCH, WAIT_DONE, FINISH.
- IDLE: `go`=1 latches `num_faces` and clears `face_idx`.
  - If the latched count is 0, go to FINISH.
  - Otherwise go to FACE_REQ.
- FACE_REQ: drive `face_addr`=`face_idx`.
- FACE_LAT: capture indices i1, i2, i3 from `face_data`.
- V_FETCH: a 2-bit counter k runs 0..3, pipelined.
  - k=0..2: drive `vert_addr`=i(k+1).
  - k=1..3: capture `vert_data` into staging register k.
  - After k=3, go to LAUNCH.
- LAUNCH: load all nine outputs from staging in the same edge (atomic update, never a partial face visible). Assert `start` for this cycle. Go to WAIT_DONE.
- WAIT_DONE: wait for `done`.
  - On `done` with `face_idx`==count-1, go to FINISH.
  - On `done` otherwise, increment `face_idx` and go to FACE_REQ.
- FINISH: `all_done`=1 for one cycle, then IDLE.
- Coordinates pass through unmodified. x = `vert_data`[15:0], y = [31:16], z = [47:32].
- Vertex index range is not checked.

## Timing
- Reset:
  - All outputs 0: `busy`, `start`, `all_done`, `face_idx`, `face_addr`, `vert_addr`, all nine coordinates.
  - Staging registers and latched count also 0; state IDLE.
  - Reset takes effect immediately. Reset mid-traversal abandons the face, and a fresh `go` is required.
- Latency: `go` in cycle 0 (IDLE) gives FACE_REQ in cycle 1, FACE_LAT in cycle 2, V_FETCH in cycles 3-6, and `start` in cycle 7.
- Face-to-face: `done` in cycle n (WAIT_DONE) gives FACE_REQ in cycle n+1 and the next `start` in cycle n+7.
- `busy`=1 from the cycle after an accepted `go` through FINISH inclusive.
- `done` is honoured only in WAIT_DONE. A `done` during LAUNCH or any other state is ignored.
- `go` outside IDLE is ignored. `go` held high across FINISH→IDLE starts a new traversal in the IDLE cycle.
- Coordinate outputs hold their values from LAUNCH until the next LAUNCH, and keep the last face's values after FINISH.
- `num_faces`=2^FACE_AW is legal; `face_idx` never wraps within a traversal.

## Structure
- `shader_pkg` holds:
  - `COORD_W`=16.
  - `vertex_t` (packed struct {z,y,x}).
  - the `face_fetch` state enum.
- Single module. No sub-module is needed; the staging bank is three `vertex_t` registers.
- The ROMs are external to this block.

## Test plan
- Reset: assert `reset` with `clk` stopped → all outputs 0 at once; `busy`=0.
- Single face:
  - Setup: `num_faces`=1, face 0={i1=2,i2=5,i3=7}; vertex 2 = x 30A9, y 1AB2, z 0100; vertex 5 = x 315F, y 1B57, z 0100; vertex 7 = x 27FC, y 1B5F, z 0100.
  - Response: `start` 7 cycles after `go` with v1x=30A9, v2y=1B57, v3x=27FC. `done` 20 cycles later → `all_done` on the next cycle, then `busy`=0.
- `num_faces`=3, bench returns `done` 1 cycle after each `start` → `face_addr` visits 0, 1, 2; three `start` pulses 8 cycles apart; exactly one `all_done`.
- `num_faces`=0 → `all_done` the cycle after `go`; no `start`; `face_addr` and `vert_addr` stay 0.
- `reset` pulsed during WAIT_DONE of face 1 of 3 → outputs 0 immediately; no `all_done`; a fresh `go` restarts at face 0.
- `done` asserted during the LAUNCH cycle and `go` pulsed while busy → both ignored; the FSM still waits for a later `done`.

Source files
------------

// File: rtl/shader_pkg.sv
// Shared types for the shader front end: coordinate width, packed vertex
// layout as stored in the vertex ROM, and the face_fetch state encoding.
package shader_pkg;

  localparam int COORD_W = 16;

  typedef struct packed {
    logic [COORD_W-1:0] z;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } vertex_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FACE_REQ,
    ST_FACE_LAT,
    ST_V_FETCH,
    ST_LAUNCH,
    ST_WAIT_DONE,
    ST_FINISH
  } ff_state_t;

endpackage

// File: rtl/face_fetch.sv
// Walks the face ROM, resolves each face's three vertices through the vertex
// ROM and hands one complete triangle at a time to the shader.
module face_fetch
  import shader_pkg::*;
#(
  parameter int FACE_AW = 10,
  parameter int VERT_AW = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 go,
  input  logic [FACE_AW:0]     num_faces,
  output logic [FACE_AW-1:0]   face_addr,
  input  logic [3*VERT_AW-1:0] face_data,
  output logic [VERT_AW-1:0]   vert_addr,
  input  logic [47:0]          vert_data,
  output logic [COORD_W-1:0]   v1x,
  output logic [COORD_W-1:0]   v1y,
  output logic [COORD_W-1:0]   v1z,
  output logic [COORD_W-1:0]   v2x,
  output logic [COORD_W-1:0]   v2y,
  output logic [COORD_W-1:0]   v2z,
  output logic [COORD_W-1:0]   v3x,
  output logic [COORD_W-1:0]   v3y,
  output logic [COORD_W-1:0]   v3z,
  output logic                 start,
  input  logic                 done,
  output logic                 busy,
  output logic [FACE_AW-1:0]   face_idx,
  output logic                 all_done
);

  localparam logic [FACE_AW:0] CNT_ONE = (FACE_AW+1)'(1);

  ff_state_t                 state_q, state_d;
  logic [FACE_AW:0]          count_q, count_d;
  logic [FACE_AW-1:0]        face_idx_q, face_idx_d;
  logic [2:0][VERT_AW-1:0]   idx_q, idx_d;
  logic [1:0]                k_q, k_d;
  vertex_t [2:0]             stage_q, stage_d;
  vertex_t [2:0]             coord_q, coord_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      face_idx_q <= '0;
      idx_q      <= '0;
      k_q        <= '0;
      stage_q    <= '0;
      coord_q    <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      face_idx_q <= face_idx_d;
      idx_q      <= idx_d;
      k_q        <= k_d;
      stage_q    <= stage_d;
      coord_q    <= coord_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    face_idx_d = face_idx_q;
    idx_d      = idx_q;
    k_d        = k_q;
    stage_d    = stage_q;
    coord_d    = coord_q;
    vert_addr  = '0;
    start      = 1'b0;
    all_done   = 1'b0;
    busy       = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          count_d    = num_faces;
          face_idx_d = '0;
          state_d    = (num_faces == '0) ? ST_FINISH : ST_FACE_REQ;
        end
      end
      ST_FACE_REQ: state_d = ST_FACE_LAT;
      ST_FACE_LAT: begin
        idx_d   = face_data;
        k_d     = 2'd0;
        state_d = ST_V_FETCH;
      end
      ST_V_FETCH: begin
        // Address for vertex k goes out while vertex k-1's data returns.
        if (k_q != 2'd3) vert_addr = idx_q[k_q];
        if (k_q != 2'd0) stage_d[k_q - 2'd1] = vertex_t'(vert_data);
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) begin
          // Third vertex bypasses staging so the whole face appears together with start.
          coord_d[0] = stage_q[0];
          coord_d[1] = stage_q[1];
          coord_d[2] = vertex_t'(vert_data);
          state_d    = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        start   = 1'b1;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (done) begin
          if (({1'b0, face_idx_q} + CNT_ONE) == count_q) begin
            state_d = ST_FINISH;
          end else begin
            face_idx_d = face_idx_q + FACE_AW'(1);
            state_d    = ST_FACE_REQ;
          end
        end
      end
      ST_FINISH: begin
        all_done = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign face_addr = face_idx_q;
  assign face_idx  = face_idx_q;

  assign v1x = coord_q[0].x;
  assign v1y = coord_q[0].y;
  assign v1z = coord_q[0].z;
  assign v2x = coord_q[1].x;
  assign v2y = coord_q[1].y;
  assign v2z = coord_q[1].z;
  assign v3x = coord_q[2].x;
  assign v3y = coord_q[2].y;
  assign v3z = coord_q[2].z;

endmodule

// File: tb/tb_face_fetch.sv
// Directed bench for face_fetch: behavioural face/vertex ROMs with one-cycle
// read latency and hand-computed expectations for each scenario.
module tb_face_fetch;
  localparam int FACE_AW = 10;
  localparam int VERT_AW = 10;

  logic                 clk = 1'b0;
  logic                 clk_run = 1'b0;
  logic                 reset = 1'b0;
  logic                 go = 1'b0;
  logic                 done = 1'b0;
  logic [FACE_AW:0]     num_faces = '0;
  logic [FACE_AW-1:0]   face_addr;
  logic [3*VERT_AW-1:0] face_data = '0;
  logic [VERT_AW-1:0]   vert_addr;
  logic [47:0]          vert_data = '0;
  logic [15:0]          v1x, v1y, v1z, v2x, v2y, v2z, v3x, v3y, v3z;
  logic                 start, busy, all_done;
  logic [FACE_AW-1:0]   face_idx;

  logic [3*VERT_AW-1:0] face_rom [0:(1<<FACE_AW)-1];
  logic [47:0]          vert_rom [0:(1<<VERT_AW)-1];
  logic [15:0]          exp_tbl  [0:2][0:2];

  int n_vec = 0, n_err = 0, cyc = 0, n_start = 0, n_alldone = 0;
  int c0, prev, ns, na;

  face_fetch #(.FACE_AW(FACE_AW), .VERT_AW(VERT_AW)) dut (
    .clk(clk), .reset(reset), .go(go), .num_faces(num_faces),
    .face_addr(face_addr), .face_data(face_data),
    .vert_addr(vert_addr), .vert_data(vert_data),
    .v1x(v1x), .v1y(v1y), .v1z(v1z), .v2x(v2x), .v2y(v2y), .v2z(v2z),
    .v3x(v3x), .v3y(v3y), .v3z(v3z),
    .start(start), .done(done), .busy(busy),
    .face_idx(face_idx), .all_done(all_done)
  );

  initial begin
    forever begin
      #5;
      if (clk_run) clk = ~clk;
    end
  end

  always @(posedge clk) begin
    face_data <= face_rom[face_addr];
    vert_data <= vert_rom[vert_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (start === 1'b1) n_start++;
    if (all_done === 1'b1) n_alldone++;
  endtask

  task automatic wait_start(input int maxc, input string tag);
    int i = 0;
    while (start !== 1'b1 && i < maxc) begin
      tick();
      i++;
    end
    if (start !== 1'b1) check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctrl"}, {busy, start, all_done}, 64'd0);
    check({tag, "_addr"}, {face_idx, face_addr, vert_addr}, 64'd0);
    check({tag, "_c0"}, {v1x, v1y, v1z, v2x}, 64'd0);
    check({tag, "_c1"}, {v2y, v2z, v3x, v3y, v3z}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1 << FACE_AW); i++) face_rom[i] = '0;
    for (int i = 0; i < (1 << VERT_AW); i++) vert_rom[i] = '0;
    face_rom[0] = {10'd7, 10'd5, 10'd2};
    face_rom[1] = {10'd4, 10'd3, 10'd1};
    face_rom[2] = {10'd9, 10'd8, 10'd6};
    vert_rom[2] = {16'h0100, 16'h1AB2, 16'h30A9};
    vert_rom[5] = {16'h0100, 16'h1B57, 16'h315F};
    vert_rom[7] = {16'h0100, 16'h1B5F, 16'h27FC};
    vert_rom[1] = {16'h3001, 16'h2001, 16'h1001};
    vert_rom[3] = {16'h3003, 16'h2003, 16'h1003};
    vert_rom[4] = {16'h3004, 16'h2004, 16'h1004};
    vert_rom[6] = {16'h3006, 16'h2006, 16'h1006};
    vert_rom[8] = {16'h3008, 16'h2008, 16'h1008};
    vert_rom[9] = {16'h3009, 16'h2009, 16'h1009};
    // expected {v1x, v2y, v3z} per face
    exp_tbl[0][0] = 16'h30A9; exp_tbl[0][1] = 16'h1B57; exp_tbl[0][2] = 16'h0100;
    exp_tbl[1][0] = 16'h1001; exp_tbl[1][1] = 16'h2003; exp_tbl[1][2] = 16'h3004;
    exp_tbl[2][0] = 16'h1006; exp_tbl[2][1] = 16'h2008; exp_tbl[2][2] = 16'h3009;

    // Asynchronous reset with the clock stopped.
    #2 reset = 1'b1;
    #1 check_zero("reset_async");
    clk_run = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Single face, latency and coordinate mapping.
    ns = n_start; na = n_alldone;
    num_faces = 1; go = 1'b1; c0 = cyc;
    tick(); go = 1'b0;
    check("t1_req_busy", busy, 1'b1);
    check("t1_req_addr", face_addr, 0);
    tick(); tick();
    check("t1_vaddr_k0", vert_addr, 2);
    tick();
    check("t1_vaddr_k1", vert_addr, 5);
    tick();
    check("t1_vaddr_k2", vert_addr, 7);
    wait_start(10, "t1_start");
    check("t1_latency", cyc - c0, 7);
    check("t1_v1", {v1x, v1y, v1z}, 48'h30A9_1AB2_0100);
    check("t1_v2", {v2x, v2y, v2z}, 48'h315F_1B57_0100);
    check("t1_v3", {v3x, v3y, v3z}, 48'h27FC_1B5F_0100);
    repeat (20) tick();
    done = 1'b1;
    tick(); done = 1'b0;
    check("t1_all_done", {all_done, busy}, 2'b11);
    tick();
    check("t1_idle", {all_done, busy}, 2'b00);
    check("t1_hold_v3x", v3x, 16'h27FC);
    check("t1_n_start", n_start - ns, 1);
    check("t1_n_alldone", n_alldone - na, 1);

    // Three faces, done one cycle after each start.
    ns = n_start; na = n_alldone;
    num_faces = 3; go = 1'b1; c0 = cyc; prev = 0;
    tick(); go = 1'b0;
    for (int f = 0; f < 3; f++) begin
      wait_start(12, "t2_start");
      check("t2_gap", (f == 0) ? (cyc - c0) : (cyc - prev), (f == 0) ? 7 : 8);
      prev = cyc;
      check("t2_face_addr", face_addr, f);
      check("t2_coords", {v1x, v2y, v3z}, {exp_tbl[f][0], exp_tbl[f][1], exp_tbl[f][2]});
      tick(); done = 1'b1;
      tick(); done = 1'b0;
    end
    check("t2_all_done", all_done, 1'b1);
    repeat (3) tick();
    check("t2_n_start", n_start - ns, 3);
    check("t2_n_alldone", n_alldone - na, 1);

    // Zero faces.
    ns = n_start; na = n_alldone;
    num_faces = 0; go = 1'b1;
    tick(); go = 1'b0;
    check("t3_finish", {all_done, busy}, 2'b11);
    check("t3_addrs", {face_addr, vert_addr}, 0);
    tick();
    check("t3_idle", {all_done, busy}, 2'b00);
    repeat (5) tick();
    check("t3_no_start", n_start - ns, 0);
    check("t3_n_alldone", n_alldone - na, 1);

    // Reset during WAIT_DONE of face 1 of 3, then fresh go.
    na = n_alldone;
    num_faces = 3; go = 1'b1;
    tick(); go = 1'b0;
    wait_start(12, "t4_start0");
    tick(); done = 1'b1;
    tick(); done = 1'b0;
    wait_start(12, "t4_start1");
    check("t4_face1", face_idx, 1);
    tick();
    #2 reset = 1'b1;
    #1 check_zero("t4_midrst");
    tick(); tick();
    reset = 1'b0;
    repeat (5) tick();
    check("t4_stay_idle", busy, 1'b0);
    check("t4_no_alldone", n_alldone - na, 0);
    num_faces = 1; go = 1'b1; c0 = cyc;
    tick(); go = 1'b0;
    wait_start(12, "t4_restart");
    check("t4_restart_lat", cyc - c0, 7);
    check("t4_restart_face", {face_idx, v1x}, {10'd0, 16'h30A9});
    tick(); done = 1'b1;
    tick(); done = 1'b0;
    check("t4_all_done", all_done, 1'b1);
    tick();

    // done during LAUNCH and go while busy are ignored.
    na = n_alldone;
    num_faces = 2; go = 1'b1;
    tick(); go = 1'b0;
    wait_start(12, "t5_start0");
    done = 1'b1; go = 1'b1;
    tick(); done = 1'b0;
    tick(); go = 1'b0;
    ns = n_start;
    repeat (5) tick();
    check("t5_no_start", n_start - ns, 0);
    check("t5_still_wait", {busy, face_idx}, {1'b1, 10'd0});
    check("t5_no_alldone", n_alldone - na, 0);
    done = 1'b1;
    tick(); done = 1'b0; c0 = cyc;
    wait_start(12, "t5_start1");
    check("t5_gap", cyc - c0, 6);
    check("t5_face1", {face_idx, v1x}, {10'd1, 16'h1001});
    tick(); done = 1'b1;
    tick(); done = 1'b0;
    check("t5_all_done", {all_done, busy}, 2'b11);
    tick();
    check("t5_idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
